// File: rtl/down_counter_tff_pkg.sv
// Shared definitions for the T-flip-flop counters.
// Default width and the per-cycle action encoding.
package down_counter_tff_pkg;

  localparam int CNT_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_DEC,
    ACT_UNDER
  } cnt_act_e;

endpackage

// File: rtl/tff_sync.sv
// Single T flip-flop with synchronous active-low clear.
// Toggles on the rising edge when t is high.
module tff_sync (
  output logic q,
  input  logic t,
  input  logic clock,
  input  logic clear_n
);

  // clear wins; otherwise toggle on t
  always_ff @(posedge clock) begin
    if (!clear_n)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/down_counter_tff.sv
// Loadable down counter built from T flip-flops.
// Option macro DOWN_COUNTER_RELOAD_EN: auto-reload on underflow.
module down_counter_tff
  import down_counter_tff_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             underflow,
  output logic             done
);

  cnt_act_e         act;
  logic [WIDTH-1:0] dec;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nxt;
  logic             uf_nxt;
  logic             done_nxt;

  assign zero = (q == '0);

  // priority decode: load > enable > hold
  always_comb begin
    act = ACT_HOLD;
    unique case (1'b1)
      load:                     act = ACT_LOAD;
      (!load && enable && !zero): act = ACT_DEC;
      (!load && enable && zero):  act = ACT_UNDER;
      default:                  act = ACT_HOLD;
    endcase
  end

  // borrow chain: bit i flips when all lower bits are 0
  always_comb begin
    logic borrow;
    borrow = 1'b1;
    dec    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = q[i] ^ borrow;
      borrow = borrow & ~q[i];
    end
  end

  // next count, reload value and flags
  always_comb begin
    nxt        = q;
    reload_nxt = reload_reg;
    uf_nxt     = 1'b0;
    done_nxt   = done;
    unique case (act)
      ACT_LOAD: begin
        nxt        = load_val;
        reload_nxt = load_val;
        done_nxt   = 1'b0;
      end
      ACT_DEC: begin
        nxt = dec;
      end
      ACT_UNDER: begin
`ifdef DOWN_COUNTER_RELOAD_EN
        nxt    = reload_reg;
        uf_nxt = 1'b1;
`else
        nxt      = q;
        uf_nxt   = ~done;
        done_nxt = 1'b1;
`endif
      end
      default: begin
        nxt = q;
      end
    endcase
  end

`ifndef DOWN_COUNTER_RELOAD_EN
  logic unused_reload;
  assign unused_reload = ^reload_reg;
`endif

  assign t = q ^ nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_sync u_tff (
      .q       (q[i]),
      .t       (t[i]),
      .clock   (clock),
      .clear_n (clear_n)
    );
  end

  // plain registers for reload value and flags
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      reload_reg <= '0;
      underflow  <= 1'b0;
      done       <= 1'b0;
    end else begin
      reload_reg <= reload_nxt;
      underflow  <= uf_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_down_counter_tff.sv
// Scoreboard bench for down_counter_tff.
// Driver pushes expected state; monitor pops after each edge.
module tb_down_counter_tff;

  typedef struct packed {
    logic [3:0] q;
    logic       z;
    logic       u;
    logic       d;
  } exp_t;

  logic       clock;
  logic       clear_n;
  logic       enable;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       zero;
  logic       underflow;
  logic       done;

  exp_t  sb[$];
  string tags[$];
  int    checks;
  int    errors;

  down_counter_tff #(.WIDTH(4)) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .enable    (enable),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .zero      (zero),
    .underflow (underflow),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // drive one cycle of inputs and queue the state expected after the edge
  task automatic step(
    input string      tag,
    input logic       cn,
    input logic       ld,
    input logic       en,
    input logic [3:0] lv,
    input logic [3:0] eq,
    input logic       eu,
    input logic       ed
  );
    exp_t e;
    @(negedge clock);
    clear_n  = cn;
    load     = ld;
    enable   = en;
    load_val = lv;
    e.q = eq;
    e.z = (eq == 4'd0);
    e.u = eu;
    e.d = ed;
    sb.push_back(e);
    tags.push_back(tag);
  endtask

  // monitor: every edge presents a new state
  always @(posedge clock) begin
    exp_t  e;
    exp_t  a;
    string tg;
    #1;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      tg = tags.pop_front();
      a  = '{q: q, z: zero, u: underflow, d: done};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s got q=%0d z=%b u=%b d=%b want q=%0d z=%b u=%b d=%b",
                 tg, a.q, a.z, a.u, a.d, e.q, e.z, e.u, e.d);
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    clear_n  = 1'b0;
    load     = 1'b1;
    enable   = 1'b1;
    load_val = 4'd7;

    step("rst0", 0, 1, 1, 4'd7, 4'd0, 0, 0);
    step("rst1", 0, 1, 1, 4'd7, 4'd0, 0, 0);

    step("ld5",  1, 1, 0, 4'd5, 4'd5, 0, 0);
    step("dec4", 1, 0, 1, 4'd0, 4'd4, 0, 0);
    step("dec3", 1, 0, 1, 4'd0, 4'd3, 0, 0);
    step("dec2", 1, 0, 1, 4'd0, 4'd2, 0, 0);
    step("dec1", 1, 0, 1, 4'd0, 4'd1, 0, 0);
    step("dec0", 1, 0, 1, 4'd0, 4'd0, 0, 0);
    step("idle0", 1, 0, 0, 4'd0, 4'd0, 0, 0);

`ifndef DOWN_COUNTER_RELOAD_EN
    step("uf1",   1, 0, 1, 4'd0, 4'd0, 1, 1);
    step("uf2",   1, 0, 1, 4'd0, 4'd0, 0, 1);
    step("uf3",   1, 0, 1, 4'd0, 4'd0, 0, 1);
    step("dhold", 1, 0, 0, 4'd0, 4'd0, 0, 1);
    step("ld2",   1, 1, 0, 4'd2, 4'd2, 0, 0);
    step("ld0",   1, 1, 0, 4'd0, 4'd0, 0, 0);
    step("uf0",   1, 0, 1, 4'd0, 4'd0, 1, 1);
    step("ld2b",  1, 1, 1, 4'd2, 4'd2, 0, 0);
`else
    step("rl3",  1, 1, 0, 4'd3, 4'd3, 0, 0);
    step("rl2",  1, 0, 1, 4'd0, 4'd2, 0, 0);
    step("rl1",  1, 0, 1, 4'd0, 4'd1, 0, 0);
    step("rl0",  1, 0, 1, 4'd0, 4'd0, 0, 0);
    step("rlw1", 1, 0, 1, 4'd0, 4'd3, 1, 0);
    step("rl2b", 1, 0, 1, 4'd0, 4'd2, 0, 0);
    step("rl1b", 1, 0, 1, 4'd0, 4'd1, 0, 0);
    step("rl0b", 1, 0, 1, 4'd0, 4'd0, 0, 0);
    step("rlw2", 1, 0, 1, 4'd0, 4'd3, 1, 0);
    step("ld2",  1, 1, 0, 4'd2, 4'd2, 0, 0);
`endif

    step("lden9", 1, 1, 1, 4'd9, 4'd9, 0, 0);
    step("hold9", 1, 0, 0, 4'd0, 4'd9, 0, 0);
    step("dec8",  1, 0, 1, 4'd0, 4'd8, 0, 0);
    step("dec7",  1, 0, 1, 4'd0, 4'd7, 0, 0);

    step("midrst", 0, 1, 1, 4'd3, 4'd0, 0, 0);
    step("ldf",    1, 1, 0, 4'd15, 4'd15, 0, 0);
    step("dec14",  1, 0, 1, 4'd0, 4'd14, 0, 0);
    step("ld4",    1, 1, 0, 4'd4, 4'd4, 0, 0);
    step("dec3b",  1, 0, 1, 4'd0, 4'd3, 0, 0);
    step("hold3",  1, 0, 0, 4'd0, 4'd3, 0, 0);

    @(negedge clock);
    enable = 1'b0;
    load   = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
